// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel counters, active-video flag, sync strobes and frame pulse.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_d,
    output logic        vs_d,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_nxt, y_nxt;
    logic       blank_nxt, hs_nxt, vs_nxt, fs_nxt;

    // Flags are decoded from the next count so they land with the counters they describe.
    always_comb begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
        blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt    = !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
        vs_nxt    = !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
        fs_nxt    = (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= blank_nxt;
            hs          <= hs_nxt;
            vs          <= vs_nxt;
            hs_d        <= hs;
            vs_d        <= vs;
            frame_start <= fs_nxt;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else if (fs_nxt)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, shrunken instance for frame-level timing.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Instance 0: 640x480 default; instance 1: 8x6 visible, 15x10 total, 150 clocks per frame.
    localparam int HV[2] = '{640, 8};
    localparam int HF[2] = '{16, 2};
    localparam int HS[2] = '{96, 3};
    localparam int HB[2] = '{48, 2};
    localparam int VV[2] = '{480, 6};
    localparam int VF[2] = '{10, 1};
    localparam int VS[2] = '{2, 2};
    localparam int VB[2] = '{33, 1};

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    logic [1:0][9:0]  ox, oy;
    logic [1:0]       obl, ohs, ovs, ohsd, ovsd, ofs;
    logic [1:0][15:0] ofc;

    int checks = 0;
    int failures = 0;

    // expected-state model
    int   mx[2], my[2], mfc[2];
    logic mbl[2], mhs[2], mvs[2], mhsd[2], mvsd[2], mfs[2];

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(ox[0]), .DrawY(oy[0]), .blank(obl[0]), .hs(ohs[0]), .vs(ovs[0]),
        .hs_d(ohsd[0]), .vs_d(ovsd[0]), .frame_start(ofs[0]), .frame_cnt(ofc[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(ox[1]), .DrawY(oy[1]), .blank(obl[1]), .hs(ohs[1]), .vs(ovs[1]),
        .hs_d(ohsd[1]), .vs_d(ovsd[1]), .frame_start(ofs[1]), .frame_cnt(ofc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = 0; my[i] = 0; mfc[i] = 0;
            mbl[i] = 1'b0; mhs[i] = 1'b1; mvs[i] = 1'b1;
            mhsd[i] = 1'b1; mvsd[i] = 1'b1; mfs[i] = 1'b0;
        end
    endtask

    task automatic mdl_step();
        int ht, vt;
        for (int i = 0; i < 2; i++) begin
            ht = HV[i] + HF[i] + HS[i] + HB[i];
            vt = VV[i] + VF[i] + VS[i] + VB[i];
            mhsd[i] = mhs[i];
            mvsd[i] = mvs[i];
            if (mx[i] == ht - 1) begin
                mx[i] = 0;
                my[i] = (my[i] == vt - 1) ? 0 : my[i] + 1;
            end else begin
                mx[i] = mx[i] + 1;
            end
            mbl[i] = (mx[i] < HV[i]) && (my[i] < VV[i]);
            mhs[i] = !((mx[i] >= HV[i] + HF[i]) && (mx[i] < HV[i] + HF[i] + HS[i]));
            mvs[i] = !((my[i] >= VV[i] + VF[i]) && (my[i] < VV[i] + VF[i] + VS[i]));
            mfs[i] = (mx[i] == 0) && (my[i] == 0);
            if (mfs[i] && CNT_EN) mfc[i] = (mfc[i] + 1) % 65536;
        end
    endtask

    task automatic cmp_all(input string pfx);
        string n;
        for (int i = 0; i < 2; i++) begin
            n = $sformatf("%s%0d_", pfx, i);
            chk({n, "DrawX"}, 32'(ox[i]), 32'(mx[i]));
            chk({n, "DrawY"}, 32'(oy[i]), 32'(my[i]));
            chk({n, "blank"}, 32'(obl[i]), 32'(mbl[i]));
            chk({n, "hs"}, 32'(ohs[i]), 32'(mhs[i]));
            chk({n, "vs"}, 32'(ovs[i]), 32'(mvs[i]));
            chk({n, "hs_d"}, 32'(ohsd[i]), 32'(mhsd[i]));
            chk({n, "vs_d"}, 32'(ovsd[i]), 32'(mvsd[i]));
            chk({n, "frame_start"}, 32'(ofs[i]), 32'(mfs[i]));
            chk({n, "frame_cnt"}, 32'(ofc[i]), 32'(mfc[i]));
        end
    endtask

    // Hand-computed reset values for both instances.
    task automatic chk_reset_vals(input string pfx);
        for (int i = 0; i < 2; i++) begin
            chk({pfx, "_DrawX"}, 32'(ox[i]), 0);
            chk({pfx, "_DrawY"}, 32'(oy[i]), 0);
            chk({pfx, "_blank"}, 32'(obl[i]), 0);
            chk({pfx, "_hs"}, 32'(ohs[i]), 1);
            chk({pfx, "_vs"}, 32'(ovs[i]), 1);
            chk({pfx, "_hs_d"}, 32'(ohsd[i]), 1);
            chk({pfx, "_vs_d"}, 32'(ovsd[i]), 1);
            chk({pfx, "_fs"}, 32'(ofs[i]), 0);
            chk({pfx, "_fcnt"}, 32'(ofc[i]), 0);
        end
    endtask

    task automatic edge_step();
        @(posedge vga_clk);
        #1;
        mdl_step();
        cmp_all("cyc");
    endtask

    initial begin
        int hs_low_d, bl_hi_d;
        int bl_hi_s, vs_low_s, hs_low_s, fs_s;

        mdl_reset();
        repeat (10) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        hs_low_d = 0; bl_hi_d = 0;
        bl_hi_s = 0; vs_low_s = 0; hs_low_s = 0; fs_s = 0;

        for (int k = 1; k <= 987; k++) begin
            edge_step();
            if (k == 1) begin
                chk("first_DrawX", 32'(ox[0]), 1);
                chk("first_DrawY", 32'(oy[0]), 0);
                chk("first_blank", 32'(obl[0]), 1);
                chk("first_hs", 32'(ohs[0]), 1);
                chk("first_vs", 32'(ovs[0]), 1);
                chk("first_hs_d", 32'(ohsd[0]), 1);
            end
            if (k == 639) chk("blank_x639", 32'(obl[0]), 1);
            if (k == 640) chk("blank_x640", 32'(obl[0]), 0);
            if (k == 655) chk("hs_x655", 32'(ohs[0]), 1);
            if (k == 656) chk("hs_x656", 32'(ohs[0]), 0);
            if (k == 657) chk("hs_d_x657", 32'(ohsd[0]), 0);
            if (k == 751) chk("hs_x751", 32'(ohs[0]), 0);
            if (k == 752) chk("hs_x752", 32'(ohs[0]), 1);
            if (k == 799) chk("x799_DrawY", 32'(oy[0]), 0);
            if (k == 800) begin
                chk("wrap_DrawX", 32'(ox[0]), 0);
                chk("wrap_DrawY", 32'(oy[0]), 1);
            end
            if (k <= 800) begin
                if (!ohs[0]) hs_low_d++;
                if (obl[0]) bl_hi_d++;
            end
            // small instance: one full frame spans k=150..299
            if (k >= 150 && k < 300) begin
                if (obl[1]) bl_hi_s++;
                if (!ovs[1]) vs_low_s++;
                if (!ohs[1]) hs_low_s++;
            end
            if (k <= 900 && ofs[1]) fs_s++;
            if (k == 149) chk("s_y9_x14", 32'({oy[1], ox[1]}), 32'({10'd9, 10'd14}));
            if (k == 150) begin
                chk("s_fs_DrawX", 32'(ox[1]), 0);
                chk("s_fs_DrawY", 32'(oy[1]), 0);
                chk("s_fs_pulse", 32'(ofs[1]), 1);
            end
            if (k == 151) chk("s_fs_end", 32'(ofs[1]), 0);
            if (k == 105) chk("s_vs_y7", 32'(ovs[1]), 0);
            if (k == 135) chk("s_vs_y9", 32'(ovs[1]), 1);
            if (k == 450) chk("s_fcnt3", 32'(ofc[1]), CNT_EN ? 3 : 0);
            if (k == 900) chk("d_fcnt0", 32'(ofc[0]), 0);
        end

        chk("d_hs_low_line", 32'(hs_low_d), 96);
        chk("d_blank_hi_line", 32'(bl_hi_d), 640);
        chk("s_blank_hi_frame", 32'(bl_hi_s), 48);
        chk("s_vs_low_frame", 32'(vs_low_s), 30);
        chk("s_hs_low_frame", 32'(hs_low_s), 30);
        chk("s_fs_count", 32'(fs_s), 6);

        // Mid-frame asynchronous reset: small instance sits at (12,5), large at (187,1).
        chk("pre_rst_s_x", 32'(ox[1]), 12);
        chk("pre_rst_s_y", 32'(oy[1]), 5);
        chk("pre_rst_d_x", 32'(ox[0]), 187);
        #6 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge vga_clk);
        chk_reset_vals("hold");
        reset_n = 1'b1;
        mdl_reset();

        for (int k = 1; k <= 200; k++) begin
            edge_step();
            if (k == 1) begin
                chk("rel_s_DrawX", 32'(ox[1]), 1);
                chk("rel_s_blank", 32'(obl[1]), 1);
            end
            if (k == 150) chk("rel_s_fs", 32'(ofs[1]), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. Runs on the 25 MHz pixel clock and produces the pixel coordinates (DrawX, DrawY), the active-video flag (blank) and the sync strobes that every sprite/board renderer stage consumes. Also provides one-cycle-delayed sync copies aligned with the renderers' registered colour outputs, plus a frame-start pulse for per-frame updates such as board state and cursor.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- vga_clk  in  1  pixel clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = active video (DrawX < H_VISIBLE and DrawY < V_VISIBLE); renderers output colour only when high
- hs  out  1  horizontal sync, active low, aligned with DrawX/DrawY
- vs  out  1  vertical sync, active low, aligned with DrawX/DrawY
- hs_d  out  1  hs delayed one vga_clk, aligned with registered renderer colour
- vs_d  out  1  vs delayed one vga_clk
- frame_start  out  1  one-cycle pulse while DrawX=0 and DrawY=0
- frame_cnt  out  16  frame counter (see Configuration)

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter increments every clock; at H_TOTAL-1 it wraps to 0 and the vertical counter advances. The vertical counter wraps from V_TOTAL-1 to 0 on the same edge that the horizontal counter wraps.
- hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
- vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
- All outputs are registers. blank, hs, vs and frame_start are decoded from the next counter value and loaded on the same edge as the counters, so they always describe the DrawX/DrawY values currently on the outputs.
- Reset (reset_n low, asynchronous): DrawX=0, DrawY=0, blank=0, hs=1, vs=1, hs_d=1, vs_d=1, frame_start=0, frame_cnt=0.
- First rising edge after reset release: counters step to (1,0), blank=1. Pixel (0,0) of the first frame is therefore blanked and that frame produces no frame_start. All subsequent frames are exact.
- Reset asserted mid-frame returns every output to its reset value immediately; no partial-line recovery.

## Timing
- Counter-to-output latency: 0 (outputs are the registers).
- hs_d/vs_d lag hs/vs by exactly one vga_clk, matching a renderer that reads ROM on negedge and registers colour on posedge.
- frame_start is high for exactly one clock per frame, every 420000 clocks.
- Line period: 800 clocks. hs low for 96 clocks per line. vs low for 2 full lines (1600 clocks).
- blank is high for 640 consecutive clocks on each of lines 0..479 and low everywhere else.

## Configuration
- VGA_FRAME_CNT_EN defined: frame_cnt increments by 1 on each edge that asserts frame_start; wraps 0xFFFF->0x0000. It is cleared only by reset.
- Not defined: frame_cnt is tied to 16'h0000 and no counter logic is instantiated. The port remains present.

## Test plan
- Reset held 10 clocks, then released -> during reset all outputs are at their reset values. After the 1st edge, DrawX=1, DrawY=0, blank=1, hs=1, vs=1.
- Run one line -> DrawX wraps 799->0 and DrawY goes 0->1 on the same edge. hs low exactly for DrawX 656..751. blank low for DrawX 640..799.
- Run a full frame -> vs low only for DrawY 490..491. DrawY wraps 524->0. frame_start pulses once, with DrawX=0 and DrawY=0. The count of blank-high clocks per frame is 307200.
- Compare hs_d/vs_d against hs/vs each clock -> hs_d(n)=hs(n-1) and vs_d(n)=vs(n-1) throughout. Both equal 1 directly after reset.
- Assert reset_n low asynchronously at DrawX=700, DrawY=300 -> outputs return to reset values without waiting for a clock edge. Counting restarts correctly after release.
- With VGA_FRAME_CNT_EN, preload by running 3 frames -> frame_cnt=3 after the third post-reset frame_start (the first partial frame has none). Without the macro, frame_cnt is 0 throughout.
